// File: rtl/fxp_sign_unit_arbiter_pkg.sv
// fxp_sign_unit_arbiter_pkg: shared types and helpers for the sign-unit arbiter
package fxp_sign_unit_arbiter_pkg;

    localparam int MAX_REQ   = 16;
    localparam int SLOT_ID_W = 4;

    typedef enum logic {
        LAT_CLS_PASS = 1'b0,
        LAT_CLS_CONV = 1'b1
    } lat_cls_e;

    typedef struct packed {
        logic                 valid;
        logic [SLOT_ID_W-1:0] id;
    } slot_t;

    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fxp_sign_unit_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick of the first eligible requester after the pointer
module rr_arbiter
    import fxp_sign_unit_arbiter_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = id_w(N)
) (
    input  logic [N-1:0]    elig_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [ID_W-1:0] idx_o,
    output logic            any_o
);

    // Scan upward from the requester after the last grant, wrapping, and take the first eligible one.
    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!any_o && elig_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/fxp_sign_unit_arbiter.sv
// fxp_sign_unit_arbiter: shares one change-sign unit among requesters, reserving result slots so returns never collide
module fxp_sign_unit_arbiter
    import fxp_sign_unit_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int FRAC_BITS = 3,
    parameter int LAT_PASS  = 1,
    parameter int LAT_CONV  = 2
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic [NUM_REQ-1:0]       REQ_VALID,
    output logic [NUM_REQ-1:0]       REQ_READY,
    input  logic [NUM_REQ*WIDTH-1:0] REQ_VALUE,
    input  logic [NUM_REQ-1:0]       REQ_SIGN,
    output logic [WIDTH-1:0]         UNIT_VALUE_IN,
    output logic                     UNIT_TARGET_SIGN,
    output logic                     UNIT_VALID_IN,
    input  logic [WIDTH-1:0]         UNIT_VALUE_OUT,
    input  logic                     UNIT_VALID_OUT,
    input  logic                     UNIT_OVERFLOW,
    output logic [NUM_REQ-1:0]       RESP_VALID,
    output logic [WIDTH-1:0]         RESP_VALUE,
    output logic                     RESP_OVERFLOW,
    output logic                     BUSY,
    output logic                     ERR_UNEXPECTED,
    output logic                     ERR_MISSING
);

    localparam int ID_W = id_w(NUM_REQ);
    localparam int D    = LAT_CONV + 1;

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || LAT_PASS < 1 || LAT_CONV <= LAT_PASS ||
        FRAC_BITS < 0 || FRAC_BITS >= WIDTH) begin : g_bad_param
        $error("fxp_sign_unit_arbiter: illegal parameter combination");
    end

    function automatic int lat_of(input lat_cls_e c);
        return (c == LAT_CLS_PASS) ? LAT_PASS : LAT_CONV;
    endfunction

    slot_t              sched_q [1:D];
    slot_t              sched_d [1:D];
    slot_t              sh      [1:D];
    lat_cls_e           cls     [NUM_REQ];
    logic [NUM_REQ-1:0] elig, gnt;
    logic [ID_W-1:0]    gnt_idx, ptr_q, ptr_d;
    logic               gnt_any, hit;
    logic [WIDTH-1:0]   unit_value_q, unit_value_d;
    logic               unit_sign_q, unit_sign_d, unit_valid_q, unit_valid_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]   resp_value_q, resp_value_d;
    logic               resp_ovf_q, resp_ovf_d;
    logic               err_unexp_q, err_unexp_d, err_miss_q, err_miss_d;

    // Reservation vector as it will look after this cycle's shift; grants are checked against it.
    always_comb begin
        sh[D] = '0;
        for (int k = 1; k < D; k++) sh[k] = sched_q[k+1];
    end

    // A requester is eligible only if the slot its result would land in is still free.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cls[i]  = (REQ_VALUE[i*WIDTH+WIDTH-1] == REQ_SIGN[i]) ? LAT_CLS_PASS : LAT_CLS_CONV;
            elig[i] = RSTN && REQ_VALID[i] && !sh[1 + lat_of(cls[i])].valid;
        end
    end

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr (
        .elig_i (elig),
        .ptr_i  (ptr_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx),
        .any_o  (gnt_any)
    );

    // Issue the granted operand, book its return slot, and route due results back to their owner.
    always_comb begin
        sched_d = sh;
        if (gnt_any) sched_d[1 + lat_of(cls[gnt_idx])] = '{valid: 1'b1, id: SLOT_ID_W'(gnt_idx)};
        hit          = sched_q[1].valid && UNIT_VALID_OUT;
        ptr_d        = gnt_any ? gnt_idx : ptr_q;
        unit_valid_d = gnt_any;
        unit_value_d = gnt_any ? REQ_VALUE[gnt_idx*WIDTH +: WIDTH] : unit_value_q;
        unit_sign_d  = gnt_any ? REQ_SIGN[gnt_idx] : unit_sign_q;
        resp_valid_d = hit ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << sched_q[1].id) : '0;
        resp_value_d = hit ? UNIT_VALUE_OUT : resp_value_q;
        resp_ovf_d   = hit ? UNIT_OVERFLOW : resp_ovf_q;
        err_unexp_d  = err_unexp_q | (UNIT_VALID_OUT & ~sched_q[1].valid);
        err_miss_d   = err_miss_q | (sched_q[1].valid & ~UNIT_VALID_OUT);
    end

    // Control state: reservations, pointer, strobes and sticky errors.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            for (int k = 1; k <= D; k++) sched_q[k] <= '0;
            ptr_q        <= ID_W'(NUM_REQ - 1);
            unit_valid_q <= 1'b0;
            resp_valid_q <= '0;
            err_unexp_q  <= 1'b0;
            err_miss_q   <= 1'b0;
        end else begin
            sched_q      <= sched_d;
            ptr_q        <= ptr_d;
            unit_valid_q <= unit_valid_d;
            resp_valid_q <= resp_valid_d;
            err_unexp_q  <= err_unexp_d;
            err_miss_q   <= err_miss_d;
        end
    end

    // Data registers need no reset; they are qualified by the valid strobes.
    always_ff @(posedge CLK) begin
        unit_value_q <= unit_value_d;
        unit_sign_q  <= unit_sign_d;
        resp_value_q <= resp_value_d;
        resp_ovf_q   <= resp_ovf_d;
    end

    // Busy while any result is booked or an issue strobe is on its way to the unit.
    always_comb begin
        BUSY = unit_valid_q;
        for (int k = 1; k <= D; k++) BUSY = BUSY | sched_q[k].valid;
    end

    assign REQ_READY        = gnt;
    assign UNIT_VALUE_IN    = unit_value_q;
    assign UNIT_TARGET_SIGN = unit_sign_q;
    assign UNIT_VALID_IN    = unit_valid_q;
    assign RESP_VALID       = resp_valid_q;
    assign RESP_VALUE       = resp_value_q;
    assign RESP_OVERFLOW    = resp_ovf_q;
    assign ERR_UNEXPECTED   = err_unexp_q;
    assign ERR_MISSING      = err_miss_q;

endmodule
